// File: rtl/mdio_pkg.sv
// Shared encodings for the MDIO programmable counter: channel modes and FSM states.
package mdio_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

endpackage : mdio_pkg

// File: rtl/mdio_prog_counter_ch.sv
// One counter channel: clear/load/advance priority with a RUN/DONE FSM.
module mdio_prog_counter_ch
   import mdio_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clr,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic [CNT_WIDTH-1:0] term_val,
   input  logic [1:0]           mode,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 tc,
   output logic                 done
);

   state_e               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 done_q;
   logic                 hit;
   logic [CNT_WIDTH-1:0] cnt_inc;

   assign hit     = (cnt_q == term_val);
   assign cnt_inc = cnt_q + CNT_WIDTH'(1);

   // Priority: reset, clear (gated by enable), load, then mode-specific advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else if (clr && enable) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else if (load) begin
         state_q <= ST_RUN;
         cnt_q   <= load_val;
         done_q  <= 1'b0;
      end else if ((state_q == ST_RUN) && enable) begin
         case (mode_e'(mode))
            MODE_SAT: begin
               if (hit) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            MODE_ONESHOT: begin
               if (hit) begin
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: cnt_q <= hit ? '0 : cnt_inc;
         endcase
      end
   end

   assign cnt  = cnt_q;
   assign done = done_q;
   assign tc   = hit;

endmodule : mdio_prog_counter_ch

// File: rtl/mdio_prog_counter.sv
// Multi-channel programmable counter for MDIO framing; channels are fully independent.
module mdio_prog_counter
   import mdio_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 5,
   parameter int unsigned NUM_CH    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             enable,
   input  logic [NUM_CH-1:0]             clr,
   input  logic [NUM_CH-1:0]             load,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   load_val,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   term_val,
   input  logic [2*NUM_CH-1:0]           mode,
   output logic [NUM_CH*CNT_WIDTH-1:0]   cnt,
   output logic [NUM_CH-1:0]             tc,
   output logic [NUM_CH-1:0]             done
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mdio_prog_counter_ch #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .enable   (enable[i]),
         .clr      (clr[i]),
         .load     (load[i]),
         .load_val (load_val[i*CNT_WIDTH +: CNT_WIDTH]),
         .term_val (term_val[i*CNT_WIDTH +: CNT_WIDTH]),
         .mode     (mode[i*2 +: 2]),
         .cnt      (cnt[i*CNT_WIDTH +: CNT_WIDTH]),
         .tc       (tc[i]),
         .done     (done[i])
      );
   end

endmodule : mdio_prog_counter

// File: tb/tb_mdio_prog_counter.sv
// Directed and randomized checks of mdio_prog_counter against a per-channel reference model.
module tb_mdio_prog_counter;

   localparam int unsigned W = 5;
   localparam int unsigned N = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   enable, clr, load;
   logic [N*W-1:0] load_val, term_val;
   logic [2*N-1:0] mode;
   logic [N*W-1:0] cnt;
   logic [N-1:0]   tc, done;

   always #5 clk = ~clk;

   mdio_prog_counter #(.CNT_WIDTH(W), .NUM_CH(N)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clr(clr), .load(load),
      .load_val(load_val), .term_val(term_val), .mode(mode),
      .cnt(cnt), .tc(tc), .done(done)
   );

   typedef struct {
      logic [N*W-1:0] cnt;
      logic [N-1:0]   done;
      logic [N-1:0]   tc;
   } exp_t;

   exp_t       sb[$];
   logic [W-1:0] m_cnt  [N];
   logic         m_done [N];
   int vectors     = 0;
   int miscompares = 0;

   int e032[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
   int e033c[6] = '{1, 2, 3, 3, 3, 3};
   int e033d[6] = '{0, 0, 0, 1, 1, 1};
   int e034c[5] = '{1, 2, 0, 0, 0};
   int e034d[5] = '{0, 0, 1, 1, 1};
   int e035[5]  = '{31, 0, 1, 2, 0};

   logic [W-1:0] tv_r [N];
   logic [1:0]   md_r [N];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(int ch, int en, int c, int ld, int lv, int tv, int md);
      enable[ch]         = (en != 0);
      clr[ch]            = (c != 0);
      load[ch]           = (ld != 0);
      load_val[ch*W +: W] = W'(lv);
      term_val[ch*W +: W] = W'(tv);
      mode[ch*2 +: 2]     = 2'(md);
   endtask

   // Reference behaviour of one clock edge for every channel.
   function automatic void model_step();
      for (int ch = 0; ch < N; ch++) begin
         logic [W-1:0] c, t, lv;
         logic [1:0]   md;
         c  = m_cnt[ch];
         t  = term_val[ch*W +: W];
         lv = load_val[ch*W +: W];
         md = mode[ch*2 +: 2];
         if (rst || (clr[ch] && enable[ch])) begin
            m_cnt[ch] = '0; m_done[ch] = 1'b0;
         end else if (load[ch]) begin
            m_cnt[ch] = lv; m_done[ch] = 1'b0;
         end else if (!m_done[ch] && enable[ch]) begin
            if (md == 2'b01) begin
               if (c == t) m_done[ch] = 1'b1;
               else        m_cnt[ch]  = c + 1'b1;
            end else if (md == 2'b10) begin
               if (c == t) begin m_cnt[ch] = '0; m_done[ch] = 1'b1; end
               else        m_cnt[ch] = c + 1'b1;
            end else begin
               m_cnt[ch] = (c == t) ? '0 : c + 1'b1;
            end
         end
      end
   endfunction

   task automatic step(string tag);
      exp_t e;
      model_step();
      for (int ch = 0; ch < N; ch++) begin
         e.cnt[ch*W +: W] = m_cnt[ch];
         e.done[ch]       = m_done[ch];
         e.tc[ch]         = (m_cnt[ch] == term_val[ch*W +: W]);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, ".cnt"},  32'(cnt),  32'(e.cnt));
      check({tag, ".done"}, 32'(done), 32'(e.done));
      check({tag, ".tc"},   32'(tc),   32'(e.tc));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = '0; clr = '0; load = '0;
      load_val = '0; term_val = '0; mode = '0;
      foreach (m_cnt[i]) begin m_cnt[i] = '0; m_done[i] = 1'b0; end
      step("reset");
      check("reset_cnt_lit", 32'(cnt), 32'd0);
      check("reset_done_lit", 32'(done), 32'd0);
      rst = 1'b0;

      // WRAP, term 5, eight enabled cycles
      drive(0, 1, 0, 0, 0, 5, 0);
      drive(1, 0, 0, 0, 0, 31, 0);
      for (int i = 0; i < 8; i++) begin
         step("wrap5");
         check("wrap5_lit", 32'(cnt[W-1:0]), 32'(e032[i]));
         check("wrap5_tc_lit", 32'(tc[0]), (i == 4) ? 32'd1 : 32'd0);
      end

      // SAT, term 3, then clear
      drive(0, 1, 1, 0, 0, 3, 1);
      step("sat_pre_clr");
      drive(0, 1, 0, 0, 0, 3, 1);
      for (int i = 0; i < 6; i++) begin
         step("sat3");
         check("sat3_cnt_lit", 32'(cnt[W-1:0]), 32'(e033c[i]));
         check("sat3_done_lit", 32'(done[0]), 32'(e033d[i]));
      end
      drive(0, 1, 1, 0, 0, 3, 1);
      step("sat3_clr");
      check("sat3_clr_lit", 32'({done[0], cnt[W-1:0]}), 32'd0);

      // ONESHOT, term 2, then load with enable low
      drive(0, 1, 0, 0, 0, 2, 2);
      for (int i = 0; i < 5; i++) begin
         step("one2");
         check("one2_cnt_lit", 32'(cnt[W-1:0]), 32'(e034c[i]));
         check("one2_done_lit", 32'(done[0]), 32'(e034d[i]));
      end
      drive(0, 0, 0, 1, 1, 2, 2);
      step("one2_load");
      check("one2_load_lit", 32'({done[0], cnt[W-1:0]}), 32'd1);

      // Load above terminal value wraps through all-ones
      drive(0, 0, 0, 1, 30, 2, 0);
      step("wrap_hi_load");
      check("wrap_hi_load_lit", 32'(cnt[W-1:0]), 32'd30);
      drive(0, 1, 0, 0, 0, 2, 0);
      for (int i = 0; i < 5; i++) begin
         step("wrap_hi");
         check("wrap_hi_lit", 32'(cnt[W-1:0]), 32'(e035[i]));
      end

      // Clear beats load
      drive(0, 0, 0, 1, 4, 31, 0);
      step("ld4");
      drive(0, 1, 1, 1, 9, 31, 0);
      step("clr_vs_load");
      check("clr_vs_load_lit", 32'(cnt[W-1:0]), 32'd0);

      // ch0 into DONE, ch1 loaded to 7, mode/term change in DONE, then reset
      drive(0, 1, 0, 0, 0, 1, 1);
      step("sat1_a");
      drive(1, 0, 0, 1, 7, 31, 0);
      step("sat1_b");
      drive(1, 0, 0, 0, 0, 31, 0);
      step("sat1_c");
      check("sat1_done_lit", 32'(done[0]), 32'd1);
      drive(0, 1, 0, 0, 0, 9, 0);
      step("done_mode_chg");
      check("done_hold_lit", 32'({done[0], cnt[W-1:0]}), 32'h21);
      check("ch1_seven_lit", 32'(cnt[2*W-1:W]), 32'd7);
      rst = 1'b1;
      step("mid_reset");
      check("mid_reset_lit", 32'({done, cnt}), 32'd0);
      rst = 1'b0;

      // WRAP with term 0 stays at zero with tc high
      drive(0, 0, 0, 0, 0, 31, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("term0");
         check("term0_lit", 32'({tc[1], cnt[2*W-1:W]}), 32'h20);
      end

      // Concurrent randomized channels in distinct modes
      for (int blk = 0; blk < 8; blk++) begin
         for (int ch = 0; ch < N; ch++) begin
            tv_r[ch] = W'($urandom_range(0, 9));
            md_r[ch] = 2'((blk + ch) % 4);
         end
         for (int i = 0; i < 30; i++) begin
            for (int ch = 0; ch < N; ch++)
               drive(ch, ($urandom_range(0, 3) != 0) ? 1 : 0,
                     ($urandom_range(0, 15) == 0) ? 1 : 0,
                     ($urandom_range(0, 15) == 0) ? 1 : 0,
                     int'($urandom_range(0, 31)), int'(tv_r[ch]), int'(md_r[ch]));
            rst = ($urandom_range(0, 63) == 0);
            step("rand");
         end
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mdio_prog_counter

// File: doc/mdio_prog_counter.md
MDIO_PROG_COUNTER -- requirements
Module: mdio_prog_counter

Interface
REQ-001 Parameter CNT_WIDTH, default 5, SHALL set the width of each channel counter in bits (5 covers the 32-bit MDIO preamble).
REQ-002 Parameter NUM_CH, default 2, SHALL set the number of independent counter channels.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 enable  input  NUM_CH  SHALL be the per-channel count enable.
REQ-006 clr  input  NUM_CH  SHALL be the per-channel clear, effective only when that channel's enable is high.
REQ-007 load  input  NUM_CH  SHALL be the per-channel load strobe, effective regardless of enable.
REQ-008 load_val  input  NUM_CH*CNT_WIDTH  SHALL give the per-channel load value; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-009 term_val  input  NUM_CH*CNT_WIDTH  SHALL give the per-channel terminal value, with the same packing as load_val.
REQ-010 mode  input  2*NUM_CH  SHALL select the per-channel mode: 00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (behaves as WRAP).
REQ-011 cnt  output  NUM_CH*CNT_WIDTH  SHALL present the registered per-channel count.
REQ-012 tc  output  NUM_CH  SHALL be a combinational level, high when cnt[i] == term_val[i].
REQ-013 done  output  NUM_CH  SHALL be the registered per-channel completion flag.

Function
REQ-014 Each channel SHALL apply one action per cycle, in this priority: rst, then clr&enable (cnt=0, done=0, state RUN), then load (cnt=load_val, done=0, state RUN), then the advance rule, else hold.
REQ-015 Each channel SHALL have a two-state FSM: RUN and DONE.
REQ-016 WRAP, RUN, enable high: if cnt==term_val then cnt SHALL go to 0, else cnt SHALL go to cnt+1; done stays 0 and the FSM never enters DONE.
REQ-017 SAT, RUN, enable high: cnt SHALL increment until it equals term_val; on the edge where cnt==term_val with enable high, cnt SHALL hold, the state SHALL go to DONE, and done SHALL go to 1.
REQ-018 ONESHOT, RUN, enable high: if cnt==term_val then cnt SHALL go to 0, the state SHALL go to DONE, and done SHALL go to 1; otherwise cnt SHALL go to cnt+1.
REQ-019 In DONE, enable SHALL be ignored and cnt SHALL hold; only rst, clr&enable, or load leave DONE.
REQ-020 The increment SHALL be modulo 2^CNT_WIDTH; if load_val > term_val, the count passes all-ones, wraps to 0 and continues to term_val.
REQ-021 With term_val=0 in WRAP, cnt SHALL stay 0 and tc SHALL stay 1 while enabled.
REQ-022 Mode and term_val SHALL be sampled every cycle; a change while in DONE SHALL NOT clear done.
REQ-023 Simultaneous load and clr with enable high: clr SHALL win. Load with enable low SHALL still load.
REQ-024 Channels SHALL be fully independent; no cross-channel interaction.
REQ-025 Latency: every control input SHALL affect cnt and done on the next rising edge; tc follows cnt with zero added latency.
REQ-026 With mode=00, load=0 and term_val=all-ones, a channel SHALL be cycle-equivalent to the previous single counter (clr gated by enable, +1 otherwise).

Reset
REQ-027 On rst high at a rising edge, every channel SHALL set cnt=0, done=0 and state RUN; this SHALL override all other inputs.
REQ-028 Reset asserted mid-count or in DONE SHALL produce the same state as reset from power-up.

Structure
REQ-029 Mode encodings (WRAP/SAT/ONESHOT) and FSM state encodings SHALL live in the shared package mdio_pkg.
REQ-030 The single-channel logic SHALL be the sub-module mdio_prog_counter_ch, instantiated NUM_CH times by generate.
REQ-031 There SHALL be no combinational path from inputs to cnt or done.

Verification
REQ-032 WRAP, term_val=5, enable held for 8 cycles from 0 -> cnt 1,2,3,4,5,0,1,2; tc high only while cnt=5.
REQ-033 SAT, term_val=3, enable for 6 cycles -> cnt 1,2,3,3,3,3; done rises on the edge after cnt=3 is seen with enable, and stays high; then clr&enable -> cnt=0, done=0.
REQ-034 ONESHOT, term_val=2, enable for 5 cycles -> cnt 1,2,0,0,0; done=1 from the third edge; then load with load_val=1 -> cnt=1, done=0.
REQ-035 load_val=30, term_val=2, CNT_WIDTH=5, WRAP -> cnt 30,31,0,1,2,0.
REQ-036 Same-cycle load=1, clr=1, enable=1 with cnt=4 -> cnt=0; rst asserted while ch0 is in DONE and ch1 at cnt=7 -> both channels cnt=0, done=0 on the next edge.
REQ-037 Two channels with different modes driven concurrently -> each channel matches its own single-channel reference model with no interference.
